// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the CPU load/store sequencer: op codes, FSM states,
// latched request payload and small decode helpers.
package mem_access_unit_pkg;

   localparam int unsigned ADDR_W  = 11;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BADDR_W = ADDR_W + 2;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LB  = 3'd1,
      OP_LBU = 3'd2,
      OP_LH  = 3'd3,
      OP_LHU = 3'd4,
      OP_SW  = 3'd5,
      OP_SB  = 3'd6,
      OP_SH  = 3'd7
   } mem_op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } mau_state_e;

   typedef struct packed {
      mem_op_e             op;
      logic [BADDR_W-1:0]  addr;
      logic [DATA_W-1:0]   wdata;
   } mem_req_t;

   function automatic logic is_store(mem_op_e op);
      return op inside {OP_SW, OP_SB, OP_SH};
   endfunction

   // Word ops need a 4-byte boundary, halfword ops a 2-byte boundary.
   function automatic logic is_misaligned(mem_op_e op, logic [1:0] lane);
      logic mis;
      mis = 1'b0;
      case (op)
         OP_LW, OP_SW:         mis = (lane != 2'b00);
         OP_LH, OP_LHU, OP_SH: mis = lane[0];
         default:              mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response and data-RAM bus between the datapath and the
// load/store sequencer.
interface mem_access_unit_if;
   import mem_access_unit_pkg::*;

   logic              req_valid;
   logic [2:0]        req_op;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] load_data;
   logic              ram_rEna;
   logic              ram_wEna;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // CPU datapath plus RAM side
   modport master (
      output req_valid, req_op, req_addr, req_wdata, ram_rdata,
      input  busy, done, err, load_data, ram_rEna, ram_wEna, ram_addr, ram_wdata
   );

   // sequencer side
   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, ram_rdata,
      output busy, done, err, load_data, ram_rEna, ram_wEna, ram_addr, ram_wdata
   );

endinterface

// File: rtl/mem_lane_align.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// sub-word store merge into the word read back from RAM (little-endian).
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  mem_op_e           op,
   input  logic [1:0]        lane,
   input  logic [DATA_W-1:0] word,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_data_next,
   output logic [DATA_W-1:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // lane selection
   always_comb begin
      byte_sel = word[7:0];
      case (lane)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      half_sel = lane[1] ? word[31:16] : word[15:0];
   end

   // load extension
   always_comb begin
      load_data_next = '0;
      case (op)
         OP_LW:   load_data_next = word;
         OP_LB:   load_data_next = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_data_next = {24'd0, byte_sel};
         OP_LH:   load_data_next = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_data_next = {16'd0, half_sel};
         default: load_data_next = '0;
      endcase
   end

   // store merge; untouched lanes keep the word read from RAM
   always_comb begin
      merged_word = word;
      case (op)
         OP_SW: merged_word = wdata;
         OP_SB: begin
            for (int k = 0; k < 4; k++) begin
               merged_word[8*k +: 8] = (lane == 2'(k)) ? wdata[7:0] : word[8*k +: 8];
            end
         end
         OP_SH: merged_word = lane[1] ? {wdata[15:0], word[15:0]}
                                      : {word[31:16], wdata[15:0]};
         default: merged_word = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the multicycle CPU and the word-only data RAM:
// single read, single write or read-modify-write per request, misalignment flagged.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   mem_access_unit_if.slave  bus
);

   mau_state_e        state, state_d;
   mem_req_t          req_q, req_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              rena_q, rena_d;
   logic              wena_q, wena_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] ld_q, ld_d;

   mem_op_e           req_op_c;
   logic [DATA_W-1:0] align_word_c;
   logic [DATA_W-1:0] ld_next_c;
   logic [DATA_W-1:0] merged_c;
   logic              unused_addr_hi;

   assign req_op_c       = mem_op_e'(bus.req_op);
   assign unused_addr_hi = ^bus.req_addr[31:BADDR_W];

   // RAM data is consumed in READ; otherwise present the last word read
   assign align_word_c = (state == S_READ) ? bus.ram_rdata : word_q;

   mem_lane_align u_align (
      .op             (req_q.op),
      .lane           (req_q.addr[1:0]),
      .word           (align_word_c),
      .wdata          (req_q.wdata),
      .load_data_next (ld_next_c),
      .merged_word    (merged_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   // next state plus next values of the registered outputs
   always_comb begin
      state_d = state;
      req_d   = req_q;
      word_d  = word_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rena_d  = 1'b0;
      wena_d  = 1'b0;
      raddr_d = raddr_q;
      wdata_d = wdata_q;
      ld_d    = ld_q;

      case (state)
         S_IDLE: begin
            if (bus.req_valid) begin
               req_d.op    = req_op_c;
               req_d.addr  = bus.req_addr[BADDR_W-1:0];
               req_d.wdata = bus.req_wdata;
               busy_d      = 1'b1;
               raddr_d     = bus.req_addr[BADDR_W-1:2];
               if (is_misaligned(req_op_c, bus.req_addr[1:0])) begin
                  state_d = S_ERR;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (req_op_c == OP_SW) begin
                  state_d = S_WRITE;
                  wena_d  = 1'b1;
                  wdata_d = bus.req_wdata;
               end else begin
                  state_d = S_READ;
                  rena_d  = 1'b1;
               end
            end
         end
         S_READ: begin
            word_d = bus.ram_rdata;
            busy_d = 1'b1;
            if (is_store(req_q.op)) begin
               state_d = S_WRITE;
               wena_d  = 1'b1;
               raddr_d = req_q.addr[BADDR_W-1:2];
               wdata_d = merged_c;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
               ld_d    = ld_next_c;
            end
         end
         S_WRITE: begin
            state_d = S_DONE;
            busy_d  = 1'b1;
            done_d  = 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // output and request registers; reset clears an in-flight write enable at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q   <= '0;
         word_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rena_q  <= 1'b0;
         wena_q  <= 1'b0;
         raddr_q <= '0;
         wdata_q <= '0;
         ld_q    <= '0;
      end else begin
         req_q   <= req_d;
         word_q  <= word_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rena_q  <= rena_d;
         wena_q  <= wena_d;
         raddr_q <= raddr_d;
         wdata_q <= wdata_d;
         ld_q    <= ld_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.load_data = ld_q;
   assign bus.ram_rEna  = rena_q;
   assign bus.ram_wEna  = wena_q;
   assign bus.ram_addr  = raddr_q;
   assign bus.ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array reference memory, RAM model,
// directed scenarios followed by randomized load/store traffic.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_unit_if bus();

   mem_access_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM: combinational read, synchronous write
   logic [31:0] ram [2048];
   assign bus.ram_rdata = ram[bus.ram_addr];

   function automatic logic [31:0] init_word(int i);
      return 32'(i) * 32'h9E37_79B1 ^ 32'hA5A5_0F0F;
   endfunction

   initial begin
      for (int i = 0; i < 2048; i++) ram[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (bus.ram_wEna) ram[bus.ram_addr] <= bus.ram_wdata;
      end
   end

   // reference: byte-addressed memory and the last completed load value
   logic [7:0]  mb [8192];
   logic [31:0] ld_last;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
      int          rd;
      int          wr;
      int          issue;
      logic [2:0]  op;
   } exp_t;
   typedef struct {
      logic [10:0] addr;
      logic [31:0] data;
   } wr_t;

   exp_t sb_q[$];
   wr_t  wr_q[$];
   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] mword(int w);
      return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
   endfunction

   // expected outcome of one request from byte-level semantics
   function automatic void model_issue(logic [2:0] op, logic [31:0] addr, logic [31:0] wdata);
      exp_t e;
      int   a;
      bit   mis;
      a   = int'(addr[12:0]);
      mis = ((op == 3'd0 || op == 3'd5) && (a % 4 != 0)) ||
            ((op == 3'd3 || op == 3'd4 || op == 3'd7) && (a % 2 != 0));
      e.issue = cyc;
      e.op    = op;
      e.err   = mis;
      e.rd    = 0;
      e.wr    = 0;
      if (mis) begin
         e.lat = 1;
      end else if (op <= 3'd4) begin
         e.lat = 2;
         e.rd  = 1;
         case (op)
            3'd0:    ld_last = mword(a / 4);
            3'd1:    ld_last = 32'($signed(mb[a]));
            3'd2:    ld_last = 32'(mb[a]);
            3'd3:    ld_last = 32'($signed({mb[a+1], mb[a]}));
            default: ld_last = 32'({mb[a+1], mb[a]});
         endcase
      end else begin
         e.wr = 1;
         if (op == 3'd5) begin
            e.lat = 2;
            for (int k = 0; k < 4; k++) mb[a+k] = wdata[8*k +: 8];
         end else begin
            e.lat = 3;
            e.rd  = 1;
            mb[a] = wdata[7:0];
            if (op == 3'd7) mb[a+1] = wdata[15:8];
         end
         wr_q.push_back('{addr: 11'(a / 4), data: mword(a / 4)});
      end
      e.data = ld_last;
      sb_q.push_back(e);
   endfunction

   // monitor: enable accounting, write checks, completion checks
   int rd_cnt = 0;
   int wr_cnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         rd_cnt = 0;
         wr_cnt = 0;
      end else begin
         if (bus.ram_rEna || bus.ram_wEna)
            chk("enables_exclusive", 32'(bus.ram_rEna & bus.ram_wEna), 32'd0);
         if (bus.ram_rEna) rd_cnt++;
         if (bus.ram_wEna) begin
            wr_t w;
            wr_cnt++;
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write addr=%h data=%h", bus.ram_addr, bus.ram_wdata);
            end else begin
               w = wr_q.pop_front();
               chk("write_addr", 32'(bus.ram_addr), 32'(w.addr));
               chk("write_data", bus.ram_wdata, w.data);
            end
         end
         if (bus.done) begin
            exp_t e;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done err=%b load_data=%h", bus.err, bus.load_data);
            end else begin
               e = sb_q.pop_front();
               chk("done_err", 32'(bus.err), 32'(e.err));
               chk("done_load_data", bus.load_data, e.data);
               chk("done_latency", 32'(cyc - e.issue), 32'(e.lat));
               chk("read_cycles", 32'(rd_cnt), 32'(e.rd));
               chk("write_cycles", 32'(wr_cnt), 32'(e.wr));
               chk("enables_at_done", 32'({bus.ram_rEna, bus.ram_wEna}), 32'd0);
            end
            rd_cnt = 0;
            wr_cnt = 0;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("idle_timeout", 32'(bus.busy), 32'd0);
   endtask

   // issue one request; optionally keep req_valid high with junk while busy
   task automatic issue(logic [2:0] op, logic [31:0] addr, logic [31:0] wdata, bit hold);
      int n = 0;
      wait_idle();
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      model_issue(op, addr, wdata);
      @(negedge clk);
      while (bus.busy && n < 20) begin
         bus.req_valid = hold;
         if (hold) begin
            bus.req_op    = 3'($urandom);
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
         end
         @(negedge clk);
         n++;
      end
      bus.req_valid = 1'b0;
      if (n >= 20) chk("done_timeout", 32'(bus.busy), 32'd0);
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_busy"},      32'(bus.busy), 32'd0);
      chk({tag, "_done"},      32'(bus.done), 32'd0);
      chk({tag, "_err"},       32'(bus.err), 32'd0);
      chk({tag, "_load_data"}, bus.load_data, 32'd0);
      chk({tag, "_rEna"},      32'(bus.ram_rEna), 32'd0);
      chk({tag, "_wEna"},      32'(bus.ram_wEna), 32'd0);
      chk({tag, "_ram_addr"},  32'(bus.ram_addr), 32'd0);
      chk({tag, "_ram_wdata"}, bus.ram_wdata, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_addr  = 32'd0;
      bus.req_wdata = 32'd0;
      ld_last       = 32'd0;
      for (int i = 0; i < 2048; i++)
         for (int k = 0; k < 4; k++) mb[4*i+k] = init_word(i)[8*k +: 8];

      #3;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // directed: word 4 values from the worked examples
      issue(3'd5, 32'h10, 32'hDEADBEEF, 1'b0);
      issue(3'd0, 32'h10, 32'h0, 1'b0);
      chk("lw_0x10", bus.load_data, 32'hDEADBEEF);
      issue(3'd1, 32'h13, 32'h0, 1'b0);
      chk("lb_0x13", bus.load_data, 32'hFFFFFFDE);
      issue(3'd2, 32'h13, 32'h0, 1'b1);
      chk("lbu_0x13", bus.load_data, 32'h000000DE);
      issue(3'd3, 32'h10, 32'h0, 1'b0);
      chk("lh_0x10", bus.load_data, 32'hFFFFBEEF);
      issue(3'd4, 32'h12, 32'h0, 1'b1);
      chk("lhu_0x12", bus.load_data, 32'h0000DEAD);
      issue(3'd6, 32'h11, 32'h12345677, 1'b0);
      chk("sb_keeps_load_data", bus.load_data, 32'h0000DEAD);
      chk("sb_ram_word", ram[4], 32'hDEAD77EF);
      issue(3'd5, 32'h10, 32'hDEADBEEF, 1'b0);
      issue(3'd7, 32'h12, 32'h0000CAFE, 1'b1);
      issue(3'd0, 32'h10, 32'h0, 1'b0);
      chk("sh_result", bus.load_data, 32'hCAFEBEEF);
      issue(3'd0, 32'h12, 32'h0, 1'b0);
      issue(3'd7, 32'h11, 32'h1111, 1'b0);
      chk("misaligned_load_data", bus.load_data, 32'hCAFEBEEF);
      chk("misaligned_ram_word", ram[4], 32'hCAFEBEEF);

      // reset during the WRITE cycle of SW 0x20
      wait_idle();
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd5;
      bus.req_addr  = 32'h20;
      bus.req_wdata = 32'h55AA55AA;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("write_cycle_wEna", 32'(bus.ram_wEna), 32'd1);
      rst = 1'b1;
      ld_last = 32'd0;
      #1;
      check_all_zero("abort");
      @(negedge clk);
      @(negedge clk);
      chk("abort_ram_word8", ram[8], mword(8));
      rst = 1'b0;
      @(negedge clk);
      issue(3'd0, 32'h20, 32'h0, 1'b0);
      chk("post_reset_lw", bus.load_data, mword(8));

      // random traffic over a small window, random upper bits exercise wrap
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         a = {19'($urandom), 6'd0, 7'($urandom_range(0, 127))};
         issue(3'($urandom), a, $urandom, 1'($urandom));
      end

      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      chk("writes_drained", 32'(wr_q.size()), 32'd0);
      for (int w = 0; w < 2048; w++) begin
         if (ram[w] !== mword(w)) chk("final_ram_word", ram[w], mword(w));
      end
      chk("final_ram_word0_32", ram[0], mword(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
